// File: rtl/prime_bus_master_if.sv
// rtl/prime_bus_master_if.sv - request/response handshakes and peripheral bus for prime_bus_master
interface prime_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    modport master (
        input  req_valid, req_n, rsp_ready, sdata_in,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output saddress, srd, swr, sdata_out
    );

    modport slave (
        output req_valid, req_n, rsp_ready, sdata_in,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  saddress, srd, swr, sdata_out
    );
endinterface

// File: rtl/prime_bus_master.sv
// rtl/prime_bus_master.sv - sequences poll/write/poll/read jobs against the prime calculator peripheral
module prime_bus_master #(
    parameter logic [15:0] ADDR_ARG     = 16'h258,
    parameter logic [15:0] ADDR_RES     = 16'h268,
    parameter logic [15:0] ADDR_STAT    = 16'h270,
    parameter int          STROBE_CYC   = 2,
    parameter int          POLL_GAP     = 4,
    parameter logic [15:0] POLL_MAX     = 16'hFFFF,
    parameter int          MAX_N        = 1000,
    parameter logic [31:0] INVALID_WORD = 32'hAAAAAAAA
) (
    input  logic                  clk,
    input  logic                  reset,
    prime_bus_master_if.master    bus,
    output logic                  busy,
    output logic [15:0]           job_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_REJECT, S_PRE_POLL, S_WRITE, S_POST_POLL, S_READ, S_RESP
    } state_t;

    // Sub-steps of one peripheral access; GAP is the quiet time before a status re-poll.
    typedef enum logic [1:0] {P_SETUP, P_STROBE, P_END, P_GAP} phase_t;

    localparam logic [7:0]  STROBE_LAST = 8'(STROBE_CYC - 1);
    localparam logic [7:0]  GAP_LAST    = 8'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LAST   = POLL_MAX - 16'd1;

    state_t      state, state_nx;
    phase_t      phase, phase_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [15:0] poll_cnt, poll_nx;
    logic [9:0]  n_reg;
    logic [31:0] rd_data;
    logic [31:0] rsp_data_q, data_nx;
    logic        rsp_err_q, err_nx;
    logic        set_rsp, job_inc;
    logic        n_ok, is_read_state, sample_rd;

    assign n_ok          = (bus.req_n != 10'd0) && ({22'd0, bus.req_n} <= 32'(MAX_N));
    assign is_read_state = (state == S_PRE_POLL) || (state == S_POST_POLL) || (state == S_READ);
    assign sample_rd     = is_read_state && (phase == P_STROBE) && (cnt == STROBE_LAST);

    // State register: FSM state, access phase, strobe/gap counter, poll counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            phase    <= P_SETUP;
            cnt      <= '0;
            poll_cnt <= '0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            cnt      <= cnt_nx;
            poll_cnt <= poll_nx;
        end
    end

    // Next-state: walk each access through SETUP/STROBE/END, decide the job step at END.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        cnt_nx   = cnt;
        poll_nx  = poll_cnt;
        set_rsp  = 1'b0;
        err_nx   = 1'b0;
        data_nx  = '0;
        job_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    phase_nx = P_SETUP;
                    cnt_nx   = '0;
                    poll_nx  = '0;
                    state_nx = n_ok ? S_PRE_POLL : S_REJECT;
                end
            end
            S_REJECT: begin
                state_nx = S_RESP;
                set_rsp  = 1'b1;
                err_nx   = 1'b1;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = S_IDLE;
                    job_inc  = !rsp_err_q;
                end
            end
            default: begin
                case (phase)
                    P_SETUP: begin
                        phase_nx = P_STROBE;
                        cnt_nx   = '0;
                    end
                    P_STROBE: begin
                        if (cnt == STROBE_LAST) phase_nx = P_END;
                        else                    cnt_nx   = cnt + 8'd1;
                    end
                    P_GAP: begin
                        if (cnt == GAP_LAST) phase_nx = P_SETUP;
                        else                 cnt_nx   = cnt + 8'd1;
                    end
                    default: begin
                        phase_nx = P_SETUP;
                        cnt_nx   = '0;
                        case (state)
                            S_PRE_POLL, S_POST_POLL: begin
                                if (rd_data[0]) begin
                                    if (poll_cnt >= POLL_LAST) begin
                                        state_nx = S_RESP;
                                        set_rsp  = 1'b1;
                                        err_nx   = 1'b1;
                                    end else begin
                                        poll_nx = poll_cnt + 16'd1;
                                        if (POLL_GAP > 0) phase_nx = P_GAP;
                                    end
                                end else begin
                                    state_nx = (state == S_PRE_POLL) ? S_WRITE : S_READ;
                                end
                            end
                            S_WRITE: begin
                                state_nx = S_POST_POLL;
                                poll_nx  = '0;
                            end
                            default: begin
                                state_nx = S_RESP;
                                set_rsp  = 1'b1;
                                if (rd_data == INVALID_WORD) err_nx  = 1'b1;
                                else                         data_nx = rd_data;
                            end
                        endcase
                    end
                endcase
            end
        endcase
    end

    // Datapath: latch N on accept, capture read data, hold the response, count good jobs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_reg      <= '0;
            rd_data    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            job_count  <= '0;
        end else begin
            if (state == S_IDLE && bus.req_valid) n_reg <= bus.req_n;
            if (sample_rd) rd_data <= bus.sdata_in;
            if (set_rsp) begin
                rsp_data_q <= data_nx;
                rsp_err_q  <= err_nx;
            end
            if (job_inc) job_count <= job_count + 16'd1;
        end
    end

    // Bus outputs decode from registered state only, so reset drops the strobe at once.
    always_comb begin
        bus.saddress  = '0;
        bus.sdata_out = '0;
        bus.srd       = 1'b0;
        bus.swr       = 1'b0;
        case (state)
            S_PRE_POLL, S_POST_POLL: begin
                bus.saddress = ADDR_STAT;
                bus.srd      = (phase == P_STROBE);
            end
            S_WRITE: begin
                bus.saddress  = ADDR_ARG;
                bus.sdata_out = {22'd0, n_reg};
                bus.swr       = (phase == P_STROBE);
            end
            S_READ: begin
                bus.saddress = ADDR_RES;
                bus.srd      = (phase == P_STROBE);
            end
            default: ;
        endcase
    end

    assign bus.req_ready = (state == S_IDLE) && !reset;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_prime_bus_master.sv
// tb/tb_prime_bus_master.sv - directed jobs against a peripheral model with a job-level reference model
module tb_prime_bus_master;

    localparam int PM    = 4;
    localparam int ACC   = 4;
    localparam int RETRY = 8;

    typedef struct packed {
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] data;
        logic        err;
    } plan_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] job_count;

    prime_bus_master_if bus();

    prime_bus_master #(.POLL_MAX(16'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .job_count (job_count)
    );

    always #5 clk = ~clk;

    int prime_tab [0:1000];
    int pre_busy  = 0;
    int post_busy = 0;
    bit bad_word  = 1'b0;
    int n_pass    = 0;
    int n_total   = 0;
    int hi_run    = 0;

    bit          m_active = 1'b0;
    int          m_since  = 0;
    plan_t       m_plan   = '0;
    logic [15:0] m_jobs   = '0;
    logic [9:0]  m_n      = '0;

    logic       srd_q     = 1'b0;
    logic       swr_q     = 1'b0;
    bit         written   = 1'b0;
    int         pre_cnt   = 0;
    int         post_cnt  = 0;
    int         rd_pulses = 0;
    int         wr_pulses = 0;
    logic [9:0] arg       = '0;

    function automatic plan_t plan(input int n, input int pre, input int post, input bit bad);
        plan_t p;
        p = '0;
        if (n == 0 || n > 1000) begin
            p.lat = 1;
            p.err = 1'b1;
        end else if (pre >= PM) begin
            p.lat = ACC + RETRY * (PM - 1);
            p.nrd = PM;
            p.err = 1'b1;
        end else if (post >= PM) begin
            p.lat = ACC + RETRY * pre + ACC + ACC + RETRY * (PM - 1);
            p.nrd = pre + 1 + PM;
            p.nwr = 1;
            p.err = 1'b1;
        end else begin
            p.lat  = 4 * ACC + RETRY * (pre + post);
            p.nrd  = pre + post + 3;
            p.nwr  = 1;
            p.err  = bad;
            p.data = bad ? 32'd0 : 32'(prime_tab[n]);
        end
        return p;
    endfunction

    // Job-level reference: what each accepted job must produce and when.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_since  <= 0;
            m_jobs   <= '0;
        end else if (!m_active) begin
            if (bus.req_valid) begin
                m_active <= 1'b1;
                m_since  <= 0;
                m_n      <= bus.req_n;
                m_plan   <= plan(int'(bus.req_n), pre_busy, post_busy, bad_word);
            end
        end else begin
            m_since <= m_since + 1;
            if (m_since >= m_plan.lat && bus.rsp_ready) begin
                m_active <= 1'b0;
                if (!m_plan.err) m_jobs <= m_jobs + 16'd1;
            end
        end
    end

    // Peripheral model: status busy for a programmed number of polls, result from the prime table.
    always @(posedge clk) begin
        srd_q <= bus.srd;
        swr_q <= bus.swr;
        if (!reset && !m_active && bus.req_valid) begin
            pre_cnt   <= 0;
            post_cnt  <= 0;
            written   <= 1'b0;
            rd_pulses <= 0;
            wr_pulses <= 0;
        end else begin
            if (bus.srd && !srd_q) rd_pulses <= rd_pulses + 1;
            if (bus.swr && !swr_q) begin
                wr_pulses <= wr_pulses + 1;
                if (bus.saddress == 16'h258) begin
                    written <= 1'b1;
                    arg     <= bus.sdata_out[9:0];
                end
            end
            if (srd_q && !bus.srd && bus.saddress == 16'h270) begin
                if (written) post_cnt <= post_cnt + 1;
                else         pre_cnt  <= pre_cnt + 1;
            end
        end
    end

    // Peripheral read data.
    always_comb begin
        bus.sdata_in = 32'd0;
        if (bus.saddress == 16'h270)
            bus.sdata_in = {31'd0, written ? (post_cnt < post_busy) : (pre_cnt < pre_busy)};
        else if (bus.saddress == 16'h268)
            bus.sdata_in = bad_word ? 32'hAAAAAAAA : ((arg <= 10'd1000) ? 32'(prime_tab[arg]) : 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic cycle_check();
        bit m_valid;
        if (reset) begin
            hi_run = 0;
            return;
        end
        m_valid = m_active && (m_since >= m_plan.lat);
        chk("srd_swr_overlap", {31'd0, bus.srd & bus.swr}, 32'd0);
        chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_valid});
        chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !m_active});
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("job_count", {16'd0, job_count}, {16'd0, m_jobs});
        if (m_valid) begin
            chk("rsp_data", bus.rsp_data, m_plan.data);
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_plan.err});
        end
        if (!m_active) chk("idle_strobe", {31'd0, bus.srd | bus.swr}, 32'd0);
        if (bus.swr) begin
            chk("wr_addr", {16'd0, bus.saddress}, 32'h258);
            chk("wr_data", bus.sdata_out, {22'd0, m_n});
        end
        if (bus.srd)
            chk("rd_addr", {31'd0, (bus.saddress == 16'h270) || (bus.saddress == 16'h268)}, 32'd1);
        if (bus.srd || bus.swr) begin
            hi_run++;
        end else begin
            if (hi_run != 0) chk("strobe_width", hi_run, 32'd2);
            hi_run = 0;
        end
        if (m_valid && bus.rsp_ready) begin
            chk("rd_pulses", rd_pulses, m_plan.nrd);
            chk("wr_pulses", wr_pulses, m_plan.nwr);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_check();
    endtask

    task automatic run_job(input logic [9:0] n, input int hold,
                           output int lat, output logic [31:0] data, output logic err);
        lat  = -1;
        data = '0;
        err  = 1'b0;
        bus.rsp_ready = (hold == 0);
        bus.req_n     = n;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!m_active) break;
            if (bus.rsp_valid && lat < 0) begin
                lat  = i;
                data = bus.rsp_data;
                err  = bus.rsp_err;
                if (hold > 0) begin
                    for (int h = 0; h < hold; h++) begin
                        tick();
                        chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
                        chk("hold_data", bus.rsp_data, data);
                        chk("hold_ready", {31'd0, bus.req_ready}, 32'd0);
                    end
                    bus.rsp_ready = 1'b1;
                end
            end
            tick();
        end
        chk("job_finished", {31'd0, m_active}, 32'd0);
        bus.rsp_ready = 1'b1;
    endtask

    initial begin
        int          np;
        bit          isp;
        int          lat;
        logic [31:0] data;
        logic        err;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_n     = '0;
        bus.rsp_ready = 1'b1;

        np = 0;
        prime_tab[0] = 0;
        for (int v = 2; np < 1000; v++) begin
            isp = 1'b1;
            for (int d = 2; d * d <= v; d++) begin
                if (v % d == 0) begin
                    isp = 1'b0;
                    break;
                end
            end
            if (isp) begin
                np++;
                prime_tab[np] = v;
            end
        end
        chk("model_p1", prime_tab[1], 32'd2);
        chk("model_p5", prime_tab[5], 32'd11);
        chk("model_p1000", prime_tab[1000], 32'd7919);

        #2;
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_srd", {31'd0, bus.srd}, 32'd0);
        chk("reset_swr", {31'd0, bus.swr}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("reset_saddress", {16'd0, bus.saddress}, 32'd0);
        chk("reset_job_count", {16'd0, job_count}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

        run_job(10'd5, 0, lat, data, err);
        chk("n5_latency", lat, 32'd16);
        chk("n5_data", data, 32'd11);
        chk("n5_err", {31'd0, err}, 32'd0);
        chk("n5_job_count", {16'd0, job_count}, 32'd1);

        run_job(10'd1, 0, lat, data, err);
        chk("n1_data", data, 32'd2);
        run_job(10'd1000, 0, lat, data, err);
        chk("n1000_data", data, 32'd7919);
        chk("n1000_latency", lat, 32'd16);
        chk("b2b_job_count", {16'd0, job_count}, 32'd3);

        run_job(10'd0, 0, lat, data, err);
        chk("n0_latency", lat, 32'd1);
        chk("n0_err", {31'd0, err}, 32'd1);
        chk("n0_data", data, 32'd0);
        run_job(10'd1001, 0, lat, data, err);
        chk("n1001_latency", lat, 32'd1);
        chk("n1001_err", {31'd0, err}, 32'd1);
        run_job(10'd1023, 0, lat, data, err);
        chk("n1023_err", {31'd0, err}, 32'd1);
        chk("illegal_job_count", {16'd0, job_count}, 32'd3);

        post_busy = 3;
        run_job(10'd10, 0, lat, data, err);
        post_busy = 0;
        chk("post_busy_latency", lat, 32'd40);
        chk("post_busy_data", data, 32'd29);

        pre_busy  = 2;
        post_busy = 1;
        run_job(10'd4, 0, lat, data, err);
        pre_busy  = 0;
        post_busy = 0;
        chk("mixed_busy_latency", lat, 32'd40);
        chk("mixed_busy_data", data, 32'd7);
        chk("busy_job_count", {16'd0, job_count}, 32'd5);

        pre_busy = 100;
        run_job(10'd7, 0, lat, data, err);
        pre_busy = 0;
        chk("timeout_latency", lat, 32'd28);
        chk("timeout_err", {31'd0, err}, 32'd1);
        chk("timeout_data", data, 32'd0);

        bad_word = 1'b1;
        run_job(10'd6, 0, lat, data, err);
        bad_word = 1'b0;
        chk("invalid_word_err", {31'd0, err}, 32'd1);
        chk("invalid_word_data", data, 32'd0);
        chk("error_job_count", {16'd0, job_count}, 32'd5);

        run_job(10'd20, 10, lat, data, err);
        chk("hold_latency", lat, 32'd16);
        chk("hold_result", data, 32'd71);
        chk("hold_job_count", {16'd0, job_count}, 32'd6);

        pre_busy      = 2;
        bus.req_n     = 10'd9;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.srd; i++) tick();
        chk("pre_reset_srd", {31'd0, bus.srd}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_srd", {31'd0, bus.srd}, 32'd0);
        chk("async_swr", {31'd0, bus.swr}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("async_saddress", {16'd0, bus.saddress}, 32'd0);
        chk("async_job_count", {16'd0, job_count}, 32'd0);
        chk("async_rsp_data", bus.rsp_data, 32'd0);
        hi_run   = 0;
        pre_busy = 0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        chk("no_rsp_after_reset", {31'd0, bus.rsp_valid}, 32'd0);

        run_job(10'd3, 0, lat, data, err);
        chk("post_reset_data", data, 32'd5);
        chk("post_reset_latency", lat, 32'd16);
        chk("post_reset_job_count", {16'd0, job_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
